bell_round_ctrl: RTL and testbench

Parametrised N-player bell round controller for the card-bell game. It latches the face-up cards and arbitrates bell presses between players, using round-robin priority on ties. It judges each press against the target-sum rule, updates signed per-player running scores with saturation, and flags a leader once one player's lead exceeds the win margin. It sits between the keypad/card front end and the LCD/score display logic.

---
 rtl/bell_round_ctrl_if.sv | 36 +++
 rtl/bell_round_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_bell_round_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bell_round_ctrl_if.sv
// Card/bell front-end and score/display signals for bell_round_ctrl.
// The slave modport is the controller side; master is the front end or bench.
`timescale 1ns/1ps
interface bell_round_ctrl_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned COLOR_W     = 2,
  parameter int unsigned NUM_W       = 3,
  parameter int unsigned POT_W       = 8,
  parameter int unsigned SCORE_W     = 10
) ();
  localparam int unsigned ID_W = $clog2(NUM_PLAYERS);

  logic                             card_valid;
  logic [NUM_PLAYERS*COLOR_W-1:0]   card_color;
  logic [NUM_PLAYERS*NUM_W-1:0]     card_num;
  logic [NUM_PLAYERS-1:0]           card_live;
  logic [NUM_PLAYERS-1:0]           bell;
  logic [POT_W-1:0]                 pot;
  logic                             busy;
  logic                             round_done;
  logic                             hit;
  logic [ID_W-1:0]                  winner_id;
  logic [NUM_PLAYERS*SCORE_W-1:0]   score_bus;
  logic                             leader_valid;
  logic [ID_W-1:0]                  leader_id;

  modport master (
    output card_valid, card_color, card_num, card_live, bell, pot,
    input  busy, round_done, hit, winner_id, score_bus, leader_valid, leader_id
  );

  modport slave (
    input  card_valid, card_color, card_num, card_live, bell, pot,
    output busy, round_done, hit, winner_id, score_bus, leader_valid, leader_id
  );
endinterface

// File: rtl/bell_round_ctrl.sv
// N-player bell round controller: latches cards, arbitrates bell presses
// round-robin, judges the target-sum rule and keeps saturating signed scores.
`timescale 1ns/1ps
module bell_round_ctrl #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned COLOR_W     = 2,
  parameter int unsigned NUM_W       = 3,
  parameter int unsigned TARGET      = 5,
  parameter int unsigned POT_W       = 8,
  parameter int unsigned SCORE_W     = 10,
  parameter int          WIN_MARGIN  = 50,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  bell_round_ctrl_if.slave bus
);
  localparam int unsigned ID_W       = $clog2(NUM_PLAYERS);
  localparam int unsigned SUM_W      = NUM_W + $clog2(NUM_PLAYERS);
  localparam int unsigned NUM_COLORS = 1 << COLOR_W;
  localparam int unsigned CNT_W      = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned EXT_W      = ((SCORE_W > POT_W) ? SCORE_W : POT_W) + 2;
  localparam int unsigned DIFF_W     = SCORE_W + 1;

  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_AWARD   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  localparam logic signed [EXT_W-1:0] S_MAX       = (EXT_W'(1) <<< (SCORE_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] S_MIN       = ~S_MAX;
  localparam logic signed [EXT_W-1:0] ONE_EXT     = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] WRONG_DELTA = $signed(-(EXT_W'(NUM_PLAYERS - 1)));

  logic [1:0]                     state_q, state_d;
  logic [NUM_PLAYERS*COLOR_W-1:0] color_q, color_d;
  logic [NUM_PLAYERS*NUM_W-1:0]   num_q, num_d;
  logic [NUM_PLAYERS-1:0]         live_q, live_d;
  logic [NUM_PLAYERS-1:0]         bell_q, bell_d;
  logic [ID_W-1:0]                rr_q, rr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ID_W-1:0]                presser_q, presser_d;
  logic                           hit_q, hit_d;
  logic [POT_W-1:0]               pot_q, pot_d;
  logic                           round_done_q, round_done_d;
  logic signed [SCORE_W-1:0]      score_q [NUM_PLAYERS];
  logic signed [SCORE_W-1:0]      score_d [NUM_PLAYERS];
  logic                           leader_valid_q, leader_valid_d;
  logic [ID_W-1:0]                leader_id_q, leader_id_d;

  logic [NUM_PLAYERS-1:0]         rise;
  logic                           sel_found;
  logic [ID_W-1:0]                sel_id;
  int unsigned                    sel_idx;
  logic                           judge_hit;
  logic [SUM_W-1:0]               color_sum;
  logic signed [EXT_W-1:0]        pot_ext;
  logic signed [EXT_W-1:0]        delta;
  logic signed [EXT_W-1:0]        acc;
  logic signed [DIFF_W-1:0]       diff;
  logic                           lead_all;

  assign rise    = bus.bell & ~bell_q;
  assign pot_ext = $signed({{(EXT_W - POT_W){1'b0}}, pot_q});

  // Round-robin: first rising bell at or after rr_q, wrapping by index.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_idx   = 0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      sel_idx = (32'(rr_q) + k) % NUM_PLAYERS;
      if (!sel_found && rise[sel_idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(sel_idx);
      end
    end
  end

  always_comb begin
    judge_hit = 1'b0;
    color_sum = '0;
    for (int unsigned c = 0; c < NUM_COLORS; c++) begin
      color_sum = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (live_q[i] && (color_q[i*COLOR_W +: COLOR_W] == COLOR_W'(c)))
          color_sum = color_sum + SUM_W'(num_q[i*NUM_W +: NUM_W]);
      end
      if (color_sum == SUM_W'(TARGET)) judge_hit = 1'b1;
    end
  end

  always_comb begin
    acc   = '0;
    delta = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = score_q[i];
    if (state_q == ST_AWARD) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (ID_W'(i) == presser_q) delta = hit_q ? pot_ext : WRONG_DELTA;
        else                       delta = hit_q ? '0 : ONE_EXT;
        acc = EXT_W'(score_q[i]) + delta;
        if (acc > S_MAX)      score_d[i] = S_MAX[SCORE_W-1:0];
        else if (acc < S_MIN) score_d[i] = S_MIN[SCORE_W-1:0];
        else                  score_d[i] = acc[SCORE_W-1:0];
      end
    end
  end

  // Differences at SCORE_W+1 bits cannot overflow; strict lead over all others.
  always_comb begin
    leader_valid_d = 1'b0;
    leader_id_d    = '0;
    lead_all       = 1'b0;
    diff           = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      lead_all = 1'b1;
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
        if (j != i) begin
          diff = DIFF_W'(score_q[i]) - DIFF_W'(score_q[j]);
          if (32'(diff) <= WIN_MARGIN) lead_all = 1'b0;
        end
      end
      if (lead_all) begin
        leader_valid_d = 1'b1;
        leader_id_d    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    num_d        = num_q;
    live_d       = live_q;
    bell_d       = bus.bell;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    presser_d    = presser_q;
    hit_d        = hit_q;
    pot_d        = pot_q;
    round_done_d = 1'b0;

    // A fresh card load beats the collect-on-hit clear in the AWARD cycle.
    if (bus.card_valid) begin
      color_d = bus.card_color;
      num_d   = bus.card_num;
      live_d  = bus.card_live;
    end else if (state_q == ST_AWARD && hit_q) begin
      live_d = '0;
    end

    case (state_q)
      ST_ARMED: begin
        if (sel_found) begin
          presser_d = sel_id;
          hit_d     = judge_hit;
          pot_d     = bus.pot;
          state_d   = ST_AWARD;
        end
      end
      ST_AWARD: begin
        state_d      = ST_LOCKOUT;
        round_done_d = 1'b1;
        cnt_d        = '0;
        rr_d         = (presser_q == ID_W'(NUM_PLAYERS - 1)) ? '0 : presser_q + ID_W'(1);
      end
      ST_LOCKOUT: begin
        if (cnt_q >= CNT_W'(LOCK_CYCLES - 1) && bus.bell == '0) state_d = ST_ARMED;
        else if (cnt_q < CNT_W'(LOCK_CYCLES - 1))               cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_ARMED;
      color_q        <= '0;
      num_q          <= '0;
      live_q         <= '0;
      bell_q         <= '0;
      rr_q           <= '0;
      cnt_q          <= '0;
      presser_q      <= '0;
      hit_q          <= 1'b0;
      pot_q          <= '0;
      round_done_q   <= 1'b0;
      leader_valid_q <= 1'b0;
      leader_id_q    <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      color_q        <= color_d;
      num_q          <= num_d;
      live_q         <= live_d;
      bell_q         <= bell_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      presser_q      <= presser_d;
      hit_q          <= hit_d;
      pot_q          <= pot_d;
      round_done_q   <= round_done_d;
      leader_valid_q <= leader_valid_d;
      leader_id_q    <= leader_id_d;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= score_d[i];
    end
  end

  always_comb begin
    bus.score_bus = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++)
      bus.score_bus[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign bus.busy         = (state_q != ST_ARMED);
  assign bus.round_done   = round_done_q;
  assign bus.hit          = hit_q;
  assign bus.winner_id    = presser_q;
  assign bus.leader_valid = leader_valid_q;
  assign bus.leader_id    = leader_id_q;
endmodule

// File: tb/tb_bell_round_ctrl.sv
// Scoreboard bench for bell_round_ctrl: directed rounds push hand-computed
// results; a monitor pops and compares on every round_done pulse.
`timescale 1ns/1ps
module tb_bell_round_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned LC = 16;

  typedef struct packed {
    logic        hit;
    logic [1:0]  win;
    logic [39:0] scores;
    logic        lv;
    logic [1:0]  lid;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q [$];

  bell_round_ctrl_if #(.NUM_PLAYERS(4), .COLOR_W(2), .NUM_W(3), .POT_W(8), .SCORE_W(10)) bus_if ();

  bell_round_ctrl #(
    .NUM_PLAYERS(4), .COLOR_W(2), .NUM_W(3), .TARGET(5), .POT_W(8),
    .SCORE_W(10), .WIN_MARGIN(50), .LOCK_CYCLES(LC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [1:0] w,
                              input int s0, input int s1, input int s2, input int s3,
                              input logic lv, input logic [1:0] lid);
    exp_t e;
    e.hit    = h;
    e.win    = w;
    e.scores = {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
    e.lv     = lv;
    e.lid    = lid;
    return e;
  endfunction

  task automatic set_cards(input logic [7:0] col, input logic [11:0] num, input logic [3:0] live);
    @(posedge clk); #1;
    bus_if.card_valid = 1'b1;
    bus_if.card_color = col;
    bus_if.card_num   = num;
    bus_if.card_live  = live;
    @(posedge clk); #1;
    bus_if.card_valid = 1'b0;
  endtask

  // Drive a press, hold the bell 'hold' cycles past E1, optionally re-press in lockout.
  task automatic press(input logic [3:0] mask, input logic [7:0] potv, input int unsigned hold,
                       input logic [3:0] repress, input logic reload, input exp_t e);
    int unsigned n;
    @(posedge clk); #1;
    sb_q.push_back(e);
    bus_if.bell = mask;
    bus_if.pot  = potv;
    @(posedge clk); #1;
    chk("busy_on_press", bus_if.busy, 1);
    if (reload) begin
      bus_if.card_valid = 1'b1;
      @(posedge clk); #1;
      bus_if.card_valid = 1'b0;
    end
    repeat (hold) @(posedge clk);
    #1;
    if (hold > LC + 4) chk("busy_while_held", bus_if.busy, 1);
    bus_if.bell = '0;
    if (repress != '0) begin
      repeat (3) @(posedge clk);
      #1 bus_if.bell = repress;
      repeat (2) @(posedge clk);
      #1 bus_if.bell = '0;
    end
    n = 0;
    while (bus_if.busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_release", bus_if.busy, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.round_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_round_done", bus_if.round_done, 0);
        end else begin
          e = sb_q.pop_front();
          chk("hit", bus_if.hit, e.hit);
          chk("winner_id", bus_if.winner_id, e.win);
          for (int i = 0; i < 4; i++)
            chk($sformatf("score_p%0d", i), bus_if.score_bus[i*10 +: 10], e.scores[i*10 +: 10]);
          @(negedge clk);
          chk("round_done_pulse", bus_if.round_done, 0);
          chk("leader_valid", bus_if.leader_valid, e.lv);
          chk("leader_id", bus_if.leader_id, e.lid);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int unsigned n;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus_if.card_valid = 1'b0;
    bus_if.card_color = '0;
    bus_if.card_num   = '0;
    bus_if.card_live  = '0;
    bus_if.bell       = '0;
    bus_if.pot        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_round_done", bus_if.round_done, 0);
    chk("rst_hit", bus_if.hit, 0);
    chk("rst_winner", bus_if.winner_id, 0);
    chk("rst_scores", bus_if.score_bus, 0);
    chk("rst_leader_valid", bus_if.leader_valid, 0);
    chk("rst_leader_id", bus_if.leader_id, 0);
    rst = 1'b1;

    // Red 2 + red 3 live; P2 red 1 is not live and must not count.
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd1, 3'd3, 3'd2}, 4'b0011);
    press(4'b0010, 8'd12, 0, 4'b0000, 1'b0, mk(1, 1, 0, 12, 0, 0, 0, 0));
    // Cards were collected: no live cards, so wrong; P1 re-press in lockout ignored.
    press(4'b0001, 8'd12, 0, 4'b0010, 1'b0, mk(0, 0, -3, 13, 1, 1, 0, 0));
    // Red 2 and blue 4: no colour sums to 5.
    set_cards({2'd0, 2'd0, 2'd1, 2'd0}, {3'd0, 3'd0, 3'd4, 3'd2}, 4'b0011);
    press(4'b0001, 8'd12, 0, 4'b0000, 1'b0, mk(0, 0, -6, 14, 2, 2, 0, 0));
    // Ties of P0 and P2: rr=1 picks P2, then rr=3 wraps to P0.
    press(4'b0101, 8'd12, 0, 4'b0000, 1'b0, mk(0, 2, -5, 15, -1, 3, 0, 0));
    press(4'b0101, 8'd12, 0, 4'b0000, 1'b0, mk(0, 0, -8, 16, 0, 4, 0, 0));
    // P3 wrong with the bell held well past the lockout length.
    press(4'b1000, 8'd12, LC + 10, 4'b0000, 1'b0, mk(0, 3, -7, 17, 1, 1, 0, 0));

    // Abort a round with an async reset during AWARD.
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd5, 3'd0}, 4'b0010);
    @(posedge clk); #1;
    bus_if.bell = 4'b0010;
    bus_if.pot  = 8'd9;
    @(posedge clk); #1;
    chk("abort_hit_latched", bus_if.hit, 1);
    chk("abort_winner_latched", bus_if.winner_id, 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_hit", bus_if.hit, 0);
    chk("abort_winner", bus_if.winner_id, 0);
    chk("abort_scores", bus_if.score_bus, 0);
    chk("abort_round_done", bus_if.round_done, 0);
    bus_if.bell = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("after_abort_busy", bus_if.busy, 0);
    chk("after_abort_scores", bus_if.score_bus, 0);

    // Leader tracking and saturation.
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100);
    press(4'b0100, 8'd60, 0, 4'b0000, 1'b0, mk(1, 2, 0, 0, 60, 0, 1, 2));
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    press(4'b0001, 8'd110, 0, 4'b0000, 1'b0, mk(1, 0, 110, 0, 60, 0, 0, 0));
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    // Card reload during AWARD must survive the collect-on-hit clear.
    press(4'b0001, 8'd1, 0, 4'b0000, 1'b1, mk(1, 0, 111, 0, 60, 0, 1, 0));
    press(4'b0001, 8'd255, 0, 4'b0000, 1'b0, mk(1, 0, 366, 0, 60, 0, 1, 0));
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    press(4'b0001, 8'd255, 0, 4'b0000, 1'b0, mk(1, 0, 511, 0, 60, 0, 1, 0));
    set_cards({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    press(4'b0001, 8'd255, 0, 4'b0000, 1'b0, mk(1, 0, 511, 0, 60, 0, 1, 0));
    // Wrong press by P1: P0 would reach 512 and must stay at 511.
    press(4'b0010, 8'd7, 0, 4'b0000, 1'b0, mk(0, 1, 511, -3, 61, 1, 1, 0));

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
